// File: rtl/adder_result_stage_if.sv
// Result channel between the adder, the result stage and its consumer.
// The stage binds to the slave modport; the driving side uses master.
interface adder_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] sum_i;
    logic             cout_i;
    logic             a_msb_i;
    logic             b_msb_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             zero_o;
    logic             neg_o;
    logic             ovf_o;

    modport slave (
        input  valid_i, sum_i, cout_i, a_msb_i, b_msb_i, ready_i,
        output ready_o, valid_o, sum_o, cout_o, zero_o, neg_o, ovf_o
    );

    modport master (
        output valid_i, sum_i, cout_i, a_msb_i, b_msb_i, ready_i,
        input  ready_o, valid_o, sum_o, cout_o, zero_o, neg_o, ovf_o
    );
endinterface

// File: rtl/adder_result_stage.sv
// Registered valid/ready output stage for the CLA adder with zero/neg/overflow flags.
// Optional transfer counter enabled by defining ADDER_RESULT_STAGE_XFER_CNT_EN.
module adder_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    adder_result_stage_if.slave  bus
`ifdef ADDER_RESULT_STAGE_XFER_CNT_EN
    ,
    input  logic                 cnt_clr_i,
    output logic [31:0]          xfer_cnt_o
`endif
);
    localparam int EW = WIDTH + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [EW-1:0]   main_reg;
    logic [EW-1:0]   skid_reg;
    logic            valid_reg;
    logic            ready_reg;
    logic [EW-1:0]   in_entry;
    logic            in_zero;
    logic            in_neg;
    logic            in_ovf;
    logic            accept;
    logic            xfer;

    // Flags are derived once at capture so the outputs stay plain register taps.
    assign in_zero  = ~|bus.sum_i;
    assign in_neg   = bus.sum_i[WIDTH-1];
    assign in_ovf   = (bus.a_msb_i == bus.b_msb_i) && (bus.sum_i[WIDTH-1] != bus.a_msb_i);
    assign in_entry = {bus.sum_i, bus.cout_i, in_zero, in_neg, in_ovf};

    assign accept = bus.valid_i && ready_reg;
    assign xfer   = valid_reg && bus.ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_reg  <= in_entry;
                        valid_reg <= 1'b1;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_reg <= in_entry;
                    end else if (accept) begin
                        // Consumer stalled: park the new result so ready can drop registered.
                        skid_reg  <= in_entry;
                        ready_reg <= 1'b0;
                        state_reg <= FULL;
                    end else if (xfer) begin
                        valid_reg <= 1'b0;
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        main_reg  <= skid_reg;
                        ready_reg <= 1'b1;
                        state_reg <= ONE;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_reg;
    assign bus.valid_o = valid_reg;
    assign bus.sum_o   = main_reg[EW-1:4];
    assign bus.cout_o  = main_reg[3];
    assign bus.zero_o  = main_reg[2];
    assign bus.neg_o   = main_reg[1];
    assign bus.ovf_o   = main_reg[0];

`ifdef ADDER_RESULT_STAGE_XFER_CNT_EN
    logic [31:0] xfer_cnt_reg;

    // Clear wins over a coincident transfer; the count wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_cnt_reg <= '0;
        end else if (cnt_clr_i) begin
            xfer_cnt_reg <= '0;
        end else if (xfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
        end
    end

    assign xfer_cnt_o = xfer_cnt_reg;
`endif
endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Registered, flow-controlled output stage that sits directly downstream of the 32-bit carry-look-ahead adder.
- Captures the adder's combinational sum and carry-out and derives status flags: zero, negative and signed overflow.
- Presents the result to the consumer through a valid/ready handshake.
- A 2-entry skid buffer keeps ready_o a pure register output, so the combinational adder path is never extended by downstream backpressure.

Parameters:
- WIDTH, 32, data width of sum_i/sum_o; minimum 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  upstream result valid this cycle.
- ready_o  output  1  stage can accept a result; registered.
- sum_i  input  WIDTH  adder sum.
- cout_i  input  1  adder carry-out.
- a_msb_i  input  1  MSB of adder operand A, used for signed overflow.
- b_msb_i  input  1  MSB of adder operand B, used for signed overflow.
- valid_o  output  1  output result valid.
- ready_i  input  1  downstream accepts.
- sum_o  output  WIDTH  registered sum.
- cout_o  output  1  registered carry-out.
- zero_o  output  1  sum_o == 0.
- neg_o  output  1  sum_o[WIDTH-1].
- ovf_o  output  1  signed overflow: (a_msb == b_msb) && (sum_msb != a_msb).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Handshake definitions:
  - Input accepted when valid_i && ready_o.
  - Output transferred when valid_o && ready_i.
- Entry contents: each entry holds {sum, cout, zero, neg, ovf}.
  - Flags are computed from sum_i/a_msb_i/b_msb_i at capture and stored, not recomputed from outputs.
- Storage: main register (drives outputs) plus one skid register.
- State machine:
  - EMPTY: valid_o=0, ready_o=1.
  - ONE: main valid, skid empty, ready_o=1.
  - FULL: main and skid valid, ready_o=0.
- Transitions:
  - EMPTY + accept -> ONE; main <= input.
  - ONE + accept + transfer -> ONE; main <= input.
  - ONE + accept, no transfer -> FULL; skid <= input.
  - ONE + transfer, no accept -> EMPTY.
  - FULL + transfer -> ONE; main <= skid. No accept is possible since ready_o=0.
  - All other cases: hold.
- Timing and ordering:
  - Latency: accepted result appears on outputs the cycle after acceptance when the stage was EMPTY or transferring.
  - Throughput: 1 result/cycle when ready_i stays high.
  - Ordering strictly preserved; no result is dropped or duplicated.
- Output stability: while valid_o=1 and ready_i=0, sum_o and all flags hold stable.
- Unaccepted input: valid_i while ready_o=0 is ignored; the upstream holds it.
- Reset values:
  - State EMPTY.
  - valid_o=0, ready_o=1.
  - sum_o=0, cout_o=0, zero_o=0, neg_o=0, ovf_o=0.
  - Skid contents=0.
- Reset mid-operation discards both entries immediately, asynchronously; the first accept after release behaves as from EMPTY.
- Flags with WIDTH>2 are computed identically; zero is a full-width reduction.

Optional Feature:
- Macro ADDER_RESULT_STAGE_XFER_CNT_EN.
- When defined:
  - Adds output xfer_cnt_o, 32 bits, counting output transfers.
  - Increments by 1 on each valid_o && ready_i cycle and wraps 0xFFFFFFFF -> 0.
  - Reset value 0.
  - Adds input cnt_clr_i, 1 bit; synchronous clear to 0 with priority over increment.
- When undefined: neither port exists; no counter logic.

Test Plan:
- Reset with valid_i=1 asserted -> valid_o=0, ready_o=1, all outputs 0; no capture until rst_i deasserts.
- Single result, ready_i=1: sum_i=0x0000_0000, cout_i=1, a_msb_i=1, b_msb_i=1 accepted at cycle N -> cycle N+1 valid_o=1, sum_o=0, cout_o=1, zero_o=1, neg_o=0, ovf_o=1; valid_o=0 at N+2.
- Backpressure: ready_i=0, push 0x7FFF_FFFF (a_msb=0, b_msb=0), then 0x8000_0000 (a_msb=0, b_msb=0) -> ready_o=0 after second accept; first output holds with ovf_o=0. Raise ready_i -> outputs 0x7FFF_FFFF then 0x8000_0000 with neg_o=1, ovf_o=1; ready_o returns to 1.
- Streaming: 100 consecutive results with random ready_i -> output sequence equals input sequence exactly; no drop or duplicate; ready_o never deasserts while ready_i held 1.
- Asynchronous reset asserted between clock edges while FULL -> valid_o falls without a clock edge; after release, the next accepted value is the first output.
- With ADDER_RESULT_STAGE_XFER_CNT_EN:
  - Counter preloaded to 0xFFFF_FFFF via 2^32 transfers or force, plus 1 transfer -> xfer_cnt_o=0.
  - cnt_clr_i asserted during a transfer -> xfer_cnt_o=0.
